// File: rtl/mulacc_if.sv
// Operand/result bundle for the shift-add multiply-accumulate unit (mulacc).
interface mulacc_if #(parameter int WIDTH = 16);
  logic             go;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             ready;
  logic             error;
  logic [WIDTH-1:0] result;

  modport master (output go, a, b, c, input ready, error, result);
  modport slave  (input go, a, b, c, output ready, error, result);
endinterface

// File: rtl/mulacc.sv
// Sequential shift-add multiply-accumulate: result = a*b + c, one multiplier bit per cycle.
// Optional macro MULACC_EARLY_EXIT_EN ends the run once the remaining multiplier bits are all zero.
module mulacc #(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  mulacc_if.slave  bus
);
  localparam int AW = 2*WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    a_q, a_d;       // multiplicand pre-shifted to the current step index
  logic [WIDTH-1:0] b_q, b_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             error_q, error_d;

  logic [AW-1:0]    sum;
  logic             last;

  assign sum = acc_q + (b_q[0] ? a_q : '0);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    error_d  = error_q;
    last     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.go) begin
          a_d     = AW'(bus.a);
          b_d     = bus.b;
          acc_d   = AW'(bus.c);
          cnt_d   = CW'(WIDTH);
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q - CW'(1);
`ifdef MULACC_EARLY_EXIT_EN
        last  = (cnt_q == CW'(1)) || (b_d == '0);
`else
        last  = (cnt_q == CW'(1));
`endif
        if (last) begin
          state_d  = IDLE;
          result_d = sum[WIDTH-1:0];
          error_d  = |sum[AW-1:WIDTH];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.error  = error_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_mulacc.sv
// Directed self-checking bench for mulacc (WIDTH=16).
module tb_mulacc;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  bit   x_seen;

  mulacc_if #(.WIDTH(16)) bus();
  mulacc #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst === 1'b1 && $isunknown({bus.ready, bus.error, bus.result})) x_seen = 1'b1;

  function automatic int exp_cyc(input logic [15:0] b);
`ifdef MULACC_EARLY_EXIT_EN
    int n;
    n = 1;
    for (int i = 0; i < 16; i++) if (b[i]) n = i + 1;
    return n;
`else
    return 16;
`endif
  endfunction

  // Launch one op with a single-cycle go and wait (bounded) for ready.
  task automatic do_op(input logic [15:0] a, b, c, output int cyc, output bit to);
    @(negedge clk);
    bus.go = 1'b1; bus.a = a; bus.b = b; bus.c = c;
    @(posedge clk); #1;
    bus.go = 1'b0;
    cyc = 0; to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.ready) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; bus.go = 1'b1; bus.a = 16'd9; bus.b = 16'd9; bus.c = 16'd9;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.ready !== 1'b1 || bus.error !== 1'b0 || bus.result !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: ready=%b error=%b result=%h, want 1 0 0000", bus.ready, bus.error, bus.result);
    end
    bus.go = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || bus.result !== 16'h0) begin
      errors++;
      $display("FAIL reset_release: ready=%b result=%h, want 1 0000", bus.ready, bus.result);
    end
  endtask

  task automatic test_basic;
    int cyc; bit to;
    do_op(16'd7, 16'd6, 16'd3, cyc, to);
    checks++;
    if (to || cyc != exp_cyc(16'd6)) begin
      errors++;
      $display("FAIL basic_latency: cycles=%0d timeout=%b, want %0d", cyc, to, exp_cyc(16'd6));
    end
    checks++;
    if (bus.result !== 16'd45 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: result=%0d error=%b, want 45 0", bus.result, bus.error);
    end
  endtask

  task automatic test_overflow;
    logic [15:0] va [3], vb [3], vc [3], vr [3];
    logic        ve [3];
    int cyc; bit to;
    va = '{16'hFFFF, 16'hFFFF, 16'h0100};
    vb = '{16'h0001, 16'h0001, 16'h0100};
    vc = '{16'h0000, 16'h0001, 16'h0005};
    vr = '{16'hFFFF, 16'h0000, 16'h0005};
    ve = '{1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 3; k++) begin
      do_op(va[k], vb[k], vc[k], cyc, to);
      checks++;
      if (to || bus.result !== vr[k] || bus.error !== ve[k]) begin
        errors++;
        $display("FAIL overflow_%0d: result=%h error=%b timeout=%b, want %h %b", k, bus.result, bus.error, to, vr[k], ve[k]);
      end
    end
  endtask

  task automatic test_round_trip;
    int cyc; bit to;
    for (int num = 0; num < 20; num++)
      for (int den = 1; den < 20; den++) begin
        do_op(16'(num / den), 16'(den), 16'(num % den), cyc, to);
        checks++;
        if (to || bus.result !== 16'(num) || bus.error !== 1'b0) begin
          errors++;
          $display("FAIL round_trip num=%0d den=%0d: result=%0d error=%b timeout=%b, want %0d 0", num, den, bus.result, bus.error, to, num);
        end
      end
    do_op(16'd0, 16'd0, 16'd0, cyc, to);
    checks++;
    if (to || bus.result !== 16'd0 || bus.error !== 1'b0 || cyc != exp_cyc(16'd0)) begin
      errors++;
      $display("FAIL zero_op: result=%0d error=%b cycles=%0d, want 0 0 %0d", bus.result, bus.error, cyc, exp_cyc(16'd0));
    end
  endtask

  // b has bit 15 set so the run lasts 16 cycles with or without early exit.
  task automatic test_ignore_go;
    int cyc; bit to; bit early_rdy;
    @(negedge clk);
    bus.go = 1'b1; bus.a = 16'd7; bus.b = 16'h8006; bus.c = 16'd3;
    @(posedge clk); #1;
    bus.go = 1'b0;
    cyc = 0; to = 1'b1; early_rdy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 5) begin bus.go = 1'b1; bus.a = 16'd1; bus.b = 16'd1; bus.c = 16'd1; end
      if (cyc == 6) bus.go = 1'b0;
      if (bus.ready) begin to = 1'b0; break; end
    end
    checks++;
    if (to || cyc != 16) begin
      errors++;
      $display("FAIL ignore_go_latency: cycles=%0d timeout=%b, want 16", cyc, to);
    end
    checks++;
    if (bus.result !== 16'h802D || bus.error !== 1'b1) begin
      errors++;
      $display("FAIL ignore_go_result: result=%h error=%b, want 802d 1", bus.result, bus.error);
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.ready !== 1'b1 || bus.result !== 16'h802D) early_rdy = 1'b1;
    end
    checks++;
    if (early_rdy) begin
      errors++;
      $display("FAIL ignore_go_no_queue: ready=%b result=%h, want 1 802d", bus.ready, bus.result);
    end
  endtask

  task automatic test_back_to_back;
    int cyc; bit to;
    @(negedge clk);
    bus.go = 1'b1; bus.a = 16'd2; bus.b = 16'd3; bus.c = 16'd1;
    @(posedge clk); #1;
    cyc = 0; to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.ready) begin to = 1'b0; break; end
    end
    checks++;
    if (to || cyc != exp_cyc(16'd3) || bus.result !== 16'd7) begin
      errors++;
      $display("FAIL b2b_first: result=%0d cycles=%0d timeout=%b, want 7 %0d", bus.result, cyc, to, exp_cyc(16'd3));
    end
    bus.a = 16'd5; bus.b = 16'd5; bus.c = 16'd0;
    @(posedge clk); #1;
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: ready=%b, want 0", bus.ready);
    end
    bus.go = 1'b0;
    cyc = 0; to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.ready) begin to = 1'b0; break; end
    end
    checks++;
    if (to || cyc != exp_cyc(16'd5) || bus.result !== 16'd25 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: result=%0d error=%b cycles=%0d, want 25 0 %0d", bus.result, bus.error, cyc, exp_cyc(16'd5));
    end
  endtask

  task automatic test_reset_mid;
    int cyc; bit to;
    @(negedge clk);
    bus.go = 1'b1; bus.a = 16'h1234; bus.b = 16'h0056; bus.c = 16'h0;
    @(posedge clk); #1;
    bus.go = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++;
    if (bus.ready !== 1'b1 || bus.error !== 1'b0 || bus.result !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid: ready=%b error=%b result=%h, want 1 0 0000", bus.ready, bus.error, bus.result);
    end
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    do_op(16'd3, 16'd4, 16'd0, cyc, to);
    checks++;
    if (to || bus.result !== 16'd12 || bus.error !== 1'b0 || cyc != exp_cyc(16'd4)) begin
      errors++;
      $display("FAIL after_reset: result=%0d error=%b cycles=%0d, want 12 0 %0d", bus.result, bus.error, cyc, exp_cyc(16'd4));
    end
  endtask

  task automatic test_no_x;
    checks++;
    if (x_seen) begin
      errors++;
      $display("FAIL no_x: unknown seen on ready/error/result, want none");
    end
  endtask

  initial begin
    errors = 0; checks = 0; x_seen = 1'b0;
    bus.go = 1'b0; bus.a = '0; bus.b = '0; bus.c = '0;
    test_reset;
    test_basic;
    test_overflow;
    test_round_trip;
    test_ignore_go;
    test_back_to_back;
    test_reset_mid;
    test_no_x;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mulacc.md
Name: mulacc

Overview:
- Sequential shift-add multiply-accumulate unit computing result = a*b + c; the arithmetic inverse of divrem (num = quot*den + rem).
- Used to rebuild candidates from divrem outputs in the prime-generation datapath, and to cross-check divrem in benches.
- Same go/ready/error handshake style as divrem; one multiplier bit retired per cycle.

Parameters:
WIDTH, 16, operand and result width in bits (>= 2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-low (0 = reset asserted)
go  input  1  start request, sampled on rising clk
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
c  input  WIDTH  addend
ready  output  1  1 = idle, result/error valid, go accepted
error  output  1  1 = true a*b+c does not fit in WIDTH bits
result  output  WIDTH  low WIDTH bits of a*b+c

Behaviour:
- Reset (rst=0, asynchronous): ready=1, error=0, result=0, FSM->IDLE, internal registers cleared. Outputs hold these values while rst=0; go is ignored.
- States: IDLE, BUSY.
- IDLE: ready=1. On a rising edge with go=1, latch a, b, c into internal registers. Accumulator (2*WIDTH+1 bits) is loaded with zero-extended c. Bit counter is set to WIDTH. Move to BUSY; ready=0 from that edge.
- BUSY, one step per edge:
  - If b_reg[0]=1, acc += a_reg shifted left by the current step index.
  - b_reg shifts right by 1; counter decrements.
  - When counter reaches 0, on that edge: go to IDLE, ready=1, result=acc[WIDTH-1:0], error = |acc[2*WIDTH:WIDTH].
- Latency: go sampled at edge N; ready=1 and result/error valid after edge N+WIDTH, i.e. WIDTH busy cycles.
- go while BUSY is ignored, with no queuing. go held high in IDLE restarts on every ready edge (back-to-back operation is allowed).
- a, b, c may change freely after the go edge; only latched values are used.
- result and error hold their values in IDLE until the next completion. During BUSY they keep the previous operation's values; they are not valid until ready=1.
- Arithmetic is unsigned. The maximum true value is (2^W-1)^2 + 2^W-1, which is below 2^(2W), so the accumulator never wraps.
- Reset mid-operation aborts immediately, returning to reset values with no partial result.

Optional Feature:
- Macro: MULACC_EARLY_EXIT_EN
- Defined: BUSY also ends on any edge where the shifted b_reg becomes 0. Busy cycles = max(1, index of the highest set bit of b + 1); b=0 takes 1 busy cycle. Result and error are identical to the full run.
- Undefined: always exactly WIDTH busy cycles, regardless of operands.

Test Plan:
- WIDTH=16, a=7, b=6, c=3, go pulsed for one cycle -> ready=0 for 16 cycles, then ready=1, result=45, error=0. With MULACC_EARLY_EXIT_EN: 3 busy cycles.
- a=0xFFFF, b=1, c=0 -> result=0xFFFF, error=0. Then a=0xFFFF, b=1, c=1 -> result=0x0000, error=1. Then a=0x0100, b=0x0100, c=5 -> result=0x0005, error=1.
- Round trip: for num 0..19 and den 1..19, feed a=num/den, b=den, c=num%den -> result=num, error=0 every time. Also a=0, b=0, c=0 -> result=0, error=0.
- go pulsed 5 cycles into a busy operation with different operands -> ignored: first result is unchanged and ready rises at the original edge. go held high continuously -> a new operation starts on each ready edge.
- rst driven low 8 cycles into a 0x1234*0x0056+0 run, asynchronously (mid-cycle) -> ready=1, error=0, result=0 immediately. After release, a fresh go with a=3, b=4, c=0 -> result=12.
- No X on ready, error, or result at any time after reset release.
